complex_fixed_mul: RTL and testbench

Pipelined signed fixed-point complex multiplier for the quantum-state datapath. It computes `out = x * y` on Q1.18 complex operands and produces a Q2.18 complex result. It is the arithmetic primitive used wherever gate-matrix coefficients are applied to state amplitudes. It takes one operand pair per clock, with no backpressure.

---
 rtl/complex_fix_pkg.sv | 14 +
 rtl/fix_mul.sv | 24 ++
 rtl/complex_fixed_mul.sv | 86 ++++++++
 tb/tb_complex_fixed_mul.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/complex_fix_pkg.sv
// Shared constants and types for the Q1.18 complex fixed-point datapath.
package complex_fix_pkg;

    localparam int WIDTH = 19;
    localparam int FRAC  = 18;

    typedef logic signed [18:0] fix_t;
    typedef logic signed [19:0] fix_wide_t;
    typedef logic signed [37:0] prod_t;

    localparam int REAL = 0;
    localparam int IMAG = 1;

endpackage

// File: rtl/fix_mul.sv
// Registered signed WIDTH x WIDTH multiplier with full-precision output.
module fix_mul #(
    parameter int WIDTH = complex_fix_pkg::WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] p_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= a * b;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/complex_fixed_mul.sv
// Two-stage pipelined signed complex multiplier, Q1.18 x Q1.18 -> Q2.18 with saturation.
// Define COMPLEX_FIXED_MUL_ROUND_EN for round-half-up scaling; otherwise the result is floored.
module complex_fixed_mul #(
    parameter int WIDTH     = complex_fix_pkg::WIDTH,
    parameter int FRAC      = complex_fix_pkg::FRAC,
    parameter int OUT_WIDTH = WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     x [0:1],
    input  logic signed [WIDTH-1:0]     y [0:1],
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out [0:1]
);

    import complex_fix_pkg::*;

    localparam int PROD_W = 2 * WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] OUT_MAX =
        {{(SUM_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        {{(SUM_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

`ifdef COMPLEX_FIXED_MUL_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = {{(SUM_W - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
`else
    localparam logic signed [SUM_W-1:0] RND = '0;
`endif

    logic signed [PROD_W-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic                        valid_q;
    logic signed [SUM_W-1:0]     sum_re, sum_im;
    logic signed [OUT_WIDTH-1:0] out_d [0:1];
    logic signed [OUT_WIDTH-1:0] out_q [0:1];
    logic                        out_valid_q;

    // Stage 1: the four partial products.
    fix_mul #(.WIDTH(WIDTH)) u_mul_rr (.clk(clk), .reset(reset), .a(x[REAL]), .b(y[REAL]), .p(p_rr));
    fix_mul #(.WIDTH(WIDTH)) u_mul_ii (.clk(clk), .reset(reset), .a(x[IMAG]), .b(y[IMAG]), .p(p_ii));
    fix_mul #(.WIDTH(WIDTH)) u_mul_ri (.clk(clk), .reset(reset), .a(x[REAL]), .b(y[IMAG]), .p(p_ri));
    fix_mul #(.WIDTH(WIDTH)) u_mul_ir (.clk(clk), .reset(reset), .a(x[IMAG]), .b(y[REAL]), .p(p_ir));

    function automatic logic signed [OUT_WIDTH-1:0] scale_sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0]     sh;
        logic signed [OUT_WIDTH-1:0] res;
        sh = (s + RND) >>> FRAC;
        if (sh > OUT_MAX) begin
            res = OUT_MAX[OUT_WIDTH-1:0];
        end else if (sh < OUT_MIN) begin
            res = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            res = sh[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

    // Stage 2: full-precision add/sub, then scale and clamp.
    always_comb begin
        sum_re      = {p_rr[PROD_W-1], p_rr} - {p_ii[PROD_W-1], p_ii};
        sum_im      = {p_ri[PROD_W-1], p_ri} + {p_ir[PROD_W-1], p_ir};
        out_d[REAL] = scale_sat(sum_re);
        out_d[IMAG] = scale_sat(sum_im);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_q[REAL] <= '0;
            out_q[IMAG] <= '0;
        end else begin
            valid_q     <= in_valid;
            out_valid_q <= valid_q;
            out_q[REAL] <= out_d[REAL];
            out_q[IMAG] <= out_d[IMAG];
        end
    end

    assign out_valid = out_valid_q;
    assign out[REAL] = out_q[REAL];
    assign out[IMAG] = out_q[IMAG];

endmodule

// File: tb/tb_complex_fixed_mul.sv
// Self-checking bench for complex_fixed_mul: vector table, streaming, random vs. model, reset.
module tb_complex_fixed_mul;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [18:0] x [0:1];
    logic signed [18:0] y [0:1];
    logic               out_valid;
    logic signed [19:0] out [0:1];

    complex_fixed_mul dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COMPLEX_FIXED_MUL_ROUND_EN
    localparam bit USE_RND = 1'b1;
`else
    localparam bit USE_RND = 1'b0;
`endif

    typedef struct {
        int xr; int xi; int yr; int yi;
        int re_r; int im_r;  // rounded
        int re_t; int im_t;  // floored
    } vec_t;

    typedef struct {
        logic v;
        int   re;
        int   im;
    } exp_t;

    vec_t tbl [5];
    exp_t pipe [$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact complex product, then floor/round by 2^18 and clamp to 20 bits.
    function automatic int ref_scale(input longint s);
        longint r;
        r = USE_RND ? (s + 64'sd131072) >>> 18 : s >>> 18;
        if (r > 64'sd524287) r = 64'sd524287;
        if (r < -64'sd524288) r = -64'sd524288;
        return int'(r);
    endfunction

    function automatic int ref_re(input int xr, input int xi, input int yr, input int yi);
        return ref_scale(longint'(xr) * longint'(yr) - longint'(xi) * longint'(yi));
    endfunction

    function automatic int ref_im(input int xr, input int xi, input int yr, input int yi);
        return ref_scale(longint'(xr) * longint'(yi) + longint'(xi) * longint'(yr));
    endfunction

    // One clock: check the result of the operands driven two steps ago, then drive new ones.
    task automatic step(input logic v, input int xr, input int xi, input int yr, input int yi,
                        input int er, input int ei);
        exp_t o;
        exp_t e;
        @(posedge clk);
        #1;
        o = pipe.pop_front();
        chk("out_valid", int'(out_valid), int'(o.v));
        if (o.v) begin
            chk("out_re", int'(out[0]), o.re);
            chk("out_im", int'(out[1]), o.im);
        end
        in_valid = v;
        x[0] = 19'(xr);
        x[1] = 19'(xi);
        y[0] = 19'(yr);
        y[1] = 19'(yi);
        e = '{v: v, re: er, im: ei};
        pipe.push_back(e);
    endtask

    task automatic step_tbl(input int i);
        step(1'b1, tbl[i].xr, tbl[i].xi, tbl[i].yr, tbl[i].yi,
             USE_RND ? tbl[i].re_r : tbl[i].re_t, USE_RND ? tbl[i].im_r : tbl[i].im_t);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pipe_clear();
        exp_t z;
        z = '{v: 1'b0, re: 0, im: 0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endtask

    initial begin
        tbl[0] = '{104176, 159610, -49594, 117945, -91521, 16675, -91522, 16675};
        tbl[1] = '{236953, 16111, -229004, 99439, -213109, 75809, -213110, 75809};
        tbl[2] = '{-143459, 171112, -7539, 107609, -66115, -63810, -66116, -63811};
        tbl[3] = '{104176, 159610, 195443, 46169, 49558, 137346, 49558, 137345};
        tbl[4] = '{-262144, -262144, -262144, -262144, 0, 524287, 0, 524287};

        reset    = 1'b1;
        in_valid = 1'b0;
        x[0] = '0; x[1] = '0; y[0] = '0; y[1] = '0;
        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_re", int'(out[0]), 0);
        chk("reset_out_im", int'(out[1]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_clear();

        // Isolated vectors, each followed by idle cycles.
        for (int i = 0; i < 5; i++) begin
            step_tbl(i);
            idle();
            idle();
        end

        // Back-to-back streaming.
        for (int i = 0; i < 5; i++) step_tbl(i);
        idle();
        idle();

        // Random traffic against the model, with occasional full-scale negative operands.
        for (int n = 0; n < 400; n++) begin
            int   ops [4];
            logic v;
            v = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                ops[k] = int'($urandom_range(0, 524287)) - 262144;
                if ($urandom_range(0, 7) == 0) ops[k] = -262144;
            end
            step(v, ops[0], ops[1], ops[2], ops[3],
                 ref_re(ops[0], ops[1], ops[2], ops[3]), ref_im(ops[0], ops[1], ops[2], ops[3]));
        end
        idle();
        idle();

        // Reset with two results in flight: outputs clear at once, nothing stale afterwards.
        step_tbl(0);
        step_tbl(1);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_re", int'(out[0]), 0);
        chk("midreset_out_im", int'(out[1]), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_clear();
        idle();
        idle();
        idle();
        step_tbl(2);
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
